// File: rtl/display_scan_driver_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan driver.
// Pin polarity is applied per bit so anode and cathode buses invert alike.
package display_scan_driver_pkg;

   localparam int unsigned SegDp = 7;

   typedef logic [SegDp:0] seg_t;

   function automatic logic pin_polarity(
      input logic value,
      input logic active_low
   );
      return value ^ active_low;
   endfunction

endpackage

// File: rtl/display_scan_driver_timebase.sv
// Scan timebase: dwell counter, digit pointer and blink divider.
// A boundary is the last cycle of a sweep, or any cycle while disabled.
module scan_timebase
   import display_scan_driver_pkg::*;
#(
   parameter int unsigned NumDigits   = 8,
   parameter int unsigned DwellCycles = 1000,
   parameter int unsigned DeadCycles  = 2,
   parameter int unsigned BlinkSweeps = 64,
   localparam int unsigned DigitW     = $clog2(NumDigits)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              enable_i,
   output logic [DigitW-1:0] digit_o,
   output logic              in_dead_o,
   output logic              boundary_o,
   output logic              blink_phase_o
);

   localparam int unsigned DwellW = $clog2(DwellCycles);
   localparam int unsigned BlinkW =
      (BlinkSweeps > 1) ? $clog2(BlinkSweeps) : 1;

   logic [DwellW-1:0] dwell_q, dwell_d;
   logic [DigitW-1:0] digit_q, digit_d;
   logic [BlinkW-1:0] blink_q, blink_d;
   logic              phase_q, phase_d;
   logic              dwell_end;
   logic              sweep_end;

   assign dwell_end = (dwell_q == DwellW'(DwellCycles - 1));
   assign sweep_end = dwell_end && (digit_q == DigitW'(NumDigits - 1));

   always_comb begin
      dwell_d = dwell_q;
      digit_d = digit_q;
      blink_d = blink_q;
      phase_d = phase_q;
      if (!enable_i) begin
         dwell_d = '0;
         digit_d = '0;
         blink_d = '0;
      end else begin
         dwell_d = dwell_end ? '0 : dwell_q + 1'b1;
         if (dwell_end) begin
            digit_d = sweep_end ? '0 : digit_q + 1'b1;
         end
         if (sweep_end) begin
            if (blink_q == BlinkW'(BlinkSweeps - 1)) begin
               blink_d = '0;
               phase_d = ~phase_q;
            end else begin
               blink_d = blink_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         dwell_q <= '0;
         digit_q <= '0;
         blink_q <= '0;
         phase_q <= 1'b0;
      end else begin
         dwell_q <= dwell_d;
         digit_q <= digit_d;
         blink_q <= blink_d;
         phase_q <= phase_d;
      end
   end

   assign digit_o       = digit_q;
   assign in_dead_o     = (dwell_q < DwellW'(DeadCycles));
   assign boundary_o    = !enable_i || sweep_end;
   assign blink_phase_o = phase_q;

endmodule

// File: rtl/display_scan_driver.sv
// Multiplexed seven-segment scan engine with double-buffered frames,
// PWM brightness, per-digit blink and selectable pin polarity.
module display_scan_driver
   import display_scan_driver_pkg::*;
#(
   parameter int unsigned NumDigits   = 8,
   parameter int unsigned DwellCycles = 1000,
   parameter int unsigned DeadCycles  = 2,
   parameter int unsigned PwmBits     = 4,
   parameter int unsigned BlinkSweeps = 64,
   parameter bit          ActiveLow   = 1'b1
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NumDigits-1:0][7:0] frame_i,
   input  logic                      frame_valid_i,
   output logic                      frame_ready_o,
   input  logic [PwmBits-1:0]        brightness_i,
   input  logic [NumDigits-1:0]      blink_mask_i,
   input  logic                      enable_i,
   output logic                      sweep_done_o,
   output logic [7:0]                segments_cathode_o,
   output logic [NumDigits-1:0]      segments_anode_o
);

   localparam int unsigned DigitW = $clog2(NumDigits);
   localparam logic        OffBit = pin_polarity(1'b0, ActiveLow);

   seg_t [NumDigits-1:0] active_q, active_d;
   seg_t [NumDigits-1:0] shadow_q, shadow_d;
   logic                 pending_q, pending_d;
   logic [PwmBits-1:0]   brightness_q, brightness_d;
   logic [PwmBits-1:0]   pwm_q, pwm_d;
   logic [NumDigits-1:0] anode_q, anode_d;
   seg_t                 cathode_q, cathode_d;
   logic                 done_q, done_d;

   logic [DigitW-1:0]    digit;
   logic                 in_dead;
   logic                 boundary;
   logic                 blink_phase;
   logic                 accept;
   logic                 swap;
   logic                 pwm_on;
   logic                 blanked;
   logic                 lit;

   scan_timebase #(
      .NumDigits  (NumDigits),
      .DwellCycles(DwellCycles),
      .DeadCycles (DeadCycles),
      .BlinkSweeps(BlinkSweeps)
   ) u_timebase (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .enable_i     (enable_i),
      .digit_o      (digit),
      .in_dead_o    (in_dead),
      .boundary_o   (boundary),
      .blink_phase_o(blink_phase)
   );

   assign accept  = frame_valid_i && !pending_q;
   assign swap    = boundary && pending_q;
   assign pwm_on  = (&brightness_q) || (pwm_q < brightness_q);
   assign blanked = blink_phase && blink_mask_i[digit];
   assign lit     = enable_i && !in_dead && pwm_on && !blanked;

   // Swap and accept are exclusive: accept needs pending clear.
   always_comb begin
      shadow_d     = shadow_q;
      active_d     = active_q;
      pending_d    = pending_q;
      brightness_d = brightness_q;
      if (swap) begin
         active_d  = shadow_q;
         pending_d = 1'b0;
      end
      if (accept) begin
         shadow_d  = frame_i;
         pending_d = 1'b1;
      end
      if (boundary) begin
         brightness_d = brightness_i;
      end
   end

   always_comb begin
      anode_d   = '0;
      cathode_d = '0;
      for (int i = 0; i < NumDigits; i++) begin
         anode_d[i] = pin_polarity(
            lit && (digit == DigitW'(i)), ActiveLow);
      end
      for (int i = 0; i <= SegDp; i++) begin
         cathode_d[i] = pin_polarity(
            lit && active_q[digit][i], ActiveLow);
      end
   end

   assign pwm_d  = pwm_q + 1'b1;
   assign done_d = boundary && enable_i;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         active_q     <= '0;
         shadow_q     <= '0;
         pending_q    <= 1'b0;
         brightness_q <= '0;
         pwm_q        <= '0;
         anode_q      <= {NumDigits{OffBit}};
         cathode_q    <= {(SegDp + 1){OffBit}};
         done_q       <= 1'b0;
      end else begin
         active_q     <= active_d;
         shadow_q     <= shadow_d;
         pending_q    <= pending_d;
         brightness_q <= brightness_d;
         pwm_q        <= pwm_d;
         anode_q      <= anode_d;
         cathode_q    <= cathode_d;
         done_q       <= done_d;
      end
   end

   assign frame_ready_o      = !pending_q;
   assign sweep_done_o       = done_q;
   assign segments_cathode_o = cathode_q;
   assign segments_anode_o   = anode_q;

endmodule
